phy_rx: RTL and testbench
=========================

PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 Parameter COM_SYM, default 8'hBC, is the comma/idle symbol the transmitter sends when no data is valid.
REQ-002 Parameter SYNC_COUNT, default 4, is the number of consecutive aligned COM bytes a lane needs to reach ACTIVE.
REQ-003 Port clk_8f, input, 1 bit: single bit-rate clock; all logic is on the rising edge.
REQ-004 Port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-005 Port enable, input, 1 bit: when high, the receiver operates; when low, it holds idle.
REQ-006 Ports rx_in_0 and rx_in_1, input, 1 bit each: serial lane inputs, one bit per clk_8f, MSB first.
REQ-007 Ports data_out_0 and data_out_1, output, 8 bits each: deserialized bytes.
REQ-008 Ports valid_out_0 and valid_out_1, output, 1 bit each: the data_out byte is a payload byte.
REQ-009 Ports active_0 and active_1, output, 1 bit each: the lane is byte-aligned and in ACTIVE.

Function
REQ-010 Each lane SHALL be processed independently, with no cross-lane dependency or deskew.
REQ-011 Each lane SHALL shift rx_in into an 8-bit register, MSB first, so that window = {shift[6:0], rx_in}.
REQ-012 Each lane SHALL implement three states: UNSYNC, SYNC_CHK and ACTIVE.
REQ-013 UNSYNC: on any cycle where window == COM_SYM, the lane SHALL move to SYNC_CHK, set com_cnt = 1 and clear the 3-bit bit counter (this is the byte boundary).
REQ-014 SYNC_CHK: at each byte boundary (bit counter wraps 7 -> 0), a window equal to COM_SYM SHALL increment com_cnt.
- When com_cnt reaches SYNC_COUNT, the lane SHALL enter ACTIVE.
- Any other byte SHALL return the lane to UNSYNC with com_cnt = 0.
REQ-015 ACTIVE: at each byte boundary, a window not equal to COM_SYM SHALL load data_out and set valid_out = 1.
- A COM_SYM window SHALL set valid_out = 0 and hold data_out.
- Both outputs SHALL hold for the 8 cycles until the next boundary.
REQ-016 Latency: data_out/valid_out SHALL update on the same clk_8f edge that samples the last (LSB) bit of the byte, i.e. be visible one cycle after the LSB is presented.
REQ-017 active_x SHALL be 1 exactly while the lane is in ACTIVE, and SHALL rise on the edge that accepts the SYNC_COUNT-th COM byte.
REQ-018 ACTIVE SHALL be left only by reset or enable = 0; a payload value equal to COM_SYM is treated as idle (the transmitter never sends COM_SYM as data).
REQ-019 The bit counter SHALL wrap 7 -> 0 freely in SYNC_CHK and ACTIVE; in UNSYNC it SHALL be don't-care but held at 0.
REQ-020 enable = 0 SHALL synchronously force UNSYNC, com_cnt = 0, valid_out = 0, data_out = 0 and active = 0; shifting SHALL continue.

Reset
REQ-021 reset_L = 0 SHALL asynchronously clear the shift registers, bit counters, com_cnt and all outputs to 0, and set both lanes to UNSYNC.
REQ-022 Reset asserted mid-byte SHALL discard the partial byte; after release, alignment SHALL restart from UNSYNC.

Configuration
REQ-023 Macro PHY_RX_STATUS_EN, when defined, SHALL add outputs com_count_0 and com_count_1 (8 bits each).
- Each counter increments per COM byte received in ACTIVE and saturates at 8'hFF.
- Each counter is cleared by reset or enable = 0.
REQ-024 When PHY_RX_STATUS_EN is undefined, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-025 The shared package phy_pkg SHALL hold the COM_SYM default, the SYNC_COUNT default and the lane state encoding (UNSYNC = 2'd0, SYNC_CHK = 2'd1, ACTIVE = 2'd2).
REQ-026 Sub-module phy_rx_lane SHALL contain the per-lane shifter, bit counter and FSM; phy_rx SHALL instantiate it twice.

Verification
REQ-027 Reset, then enable = 1 and 5 x 0xBC on lane 0 starting at an arbitrary bit offset -> active_0 = 1 on the edge sampling the LSB of the 4th aligned BC; valid_out_0 = 0.
REQ-028 After sync, send 0x5A then 0xBC -> data_out_0 = 0x5A with valid_out_0 = 1 for 8 cycles, then valid_out_0 = 0 with data_out_0 holding 0x5A.
REQ-029 During SYNC_CHK, send 0xBC, 0xBC, 0x33 -> lane returns to UNSYNC and active_0 stays 0; 4 further BCs -> active_0 = 1.
REQ-030 Lane 1 skewed 3 bits from lane 0, each sending BC x4 then 0x01, 0xFF -> each lane outputs 0x01 then 0xFF at its own boundaries; outputs are independent.
REQ-031 reset_L pulsed low at bit 4 of a payload byte -> all outputs 0 immediately (asynchronous); after release, re-sync takes 4 BCs.
REQ-032 With PHY_RX_STATUS_EN, 300 idle BCs in ACTIVE -> com_count_0 = 8'hFF; enable = 0 -> com_count_0 = 0 and active_0 = 0 on the next edge.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared definitions for the phy_rx receiver: default comma symbol, sync depth
// and the per-lane alignment state encoding.
package phy_pkg;

  localparam logic [7:0] COM_SYM_DEF    = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    UNSYNC   = 2'd0,
    SYNC_CHK = 2'd1,
    ACTIVE   = 2'd2
  } lane_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// One serial receive lane: MSB-first shifter, comma-based byte alignment FSM
// and byte output register. PHY_RX_STATUS_EN adds a saturating idle-COM counter.
module phy_rx_lane
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_o
`ifdef PHY_RX_STATUS_EN
  ,
  output logic [7:0] com_count_o
`endif
);

  localparam int CW = $clog2(SYNC_COUNT + 1);

  lane_state_e   state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d, com_inc;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [7:0]    window;
  logic          is_com, boundary;
  logic          shift_msb_unused;

  // Only the low seven history bits feed the window; bit 7 is the byte that just left.
  assign window           = {shift_q[6:0], rx_i};
  assign shift_msb_unused = shift_q[7];
  assign is_com           = (window == COM_SYM);
  assign boundary         = (bit_cnt_q == 3'd7);
  assign com_inc          = com_cnt_q + CW'(1);

`ifdef PHY_RX_STATUS_EN
  logic [7:0] stat_q, stat_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
`ifdef PHY_RX_STATUS_EN
    stat_d    = stat_q;
`endif
    if (!enable_i) begin
      state_d   = UNSYNC;
      bit_cnt_d = 3'd0;
      com_cnt_d = '0;
      data_d    = 8'h00;
      valid_d   = 1'b0;
`ifdef PHY_RX_STATUS_EN
      stat_d    = 8'h00;
`endif
    end else begin
      unique case (state_q)
        UNSYNC: begin
          // Any bit position may be the comma; matching it defines the byte boundary.
          bit_cnt_d = 3'd0;
          if (is_com) begin
            com_cnt_d = CW'(1);
            state_d   = (SYNC_COUNT <= 1) ? ACTIVE : SYNC_CHK;
          end
        end
        SYNC_CHK: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt_d = com_inc;
              if (com_inc == CW'(SYNC_COUNT)) state_d = ACTIVE;
            end else begin
              state_d   = UNSYNC;
              com_cnt_d = '0;
              bit_cnt_d = 3'd0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            if (is_com) begin
              valid_d = 1'b0;
`ifdef PHY_RX_STATUS_EN
              stat_d  = sat_inc8(stat_q);
`endif
            end else begin
              data_d  = window;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d   = UNSYNC;
          bit_cnt_d = 3'd0;
          com_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= UNSYNC;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= window;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

`ifdef PHY_RX_STATUS_EN
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) stat_q <= 8'h00;
    else          stat_q <= stat_d;
  end
  assign com_count_o = stat_q;
`endif

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign active_o = (state_q == ACTIVE);

endmodule

// File: rtl/phy_rx.sv
// Two-lane serial receiver; lanes align and deserialize independently (no deskew).
// Define PHY_RX_STATUS_EN to expose per-lane idle-COM counters com_count_0/1.
module phy_rx
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       rx_in_0,
  input  logic       rx_in_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       active_0,
  output logic       active_1
`ifdef PHY_RX_STATUS_EN
  ,
  output logic [7:0] com_count_0,
  output logic [7:0] com_count_1
`endif
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]      rx_vec, vld_vec, act_vec;
  logic [NUM_LANES-1:0][7:0] data_vec;
`ifdef PHY_RX_STATUS_EN
  logic [NUM_LANES-1:0][7:0] cnt_vec;
`endif

  assign rx_vec = {rx_in_1, rx_in_0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    phy_rx_lane #(
      .COM_SYM   (COM_SYM),
      .SYNC_COUNT(SYNC_COUNT)
    ) u_lane (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .enable_i(enable),
      .rx_i    (rx_vec[g]),
      .data_o  (data_vec[g]),
      .valid_o (vld_vec[g]),
      .active_o(act_vec[g])
`ifdef PHY_RX_STATUS_EN
      ,
      .com_count_o(cnt_vec[g])
`endif
    );
  end

  assign data_out_0  = data_vec[0];
  assign data_out_1  = data_vec[1];
  assign valid_out_0 = vld_vec[0];
  assign valid_out_1 = vld_vec[1];
  assign active_0    = act_vec[0];
  assign active_1    = act_vec[1];
`ifdef PHY_RX_STATUS_EN
  assign com_count_0 = cnt_vec[0];
  assign com_count_1 = cnt_vec[1];
`endif

endmodule

// File: tb/tb_phy_rx.sv
// Self-checking bench for phy_rx: directed alignment/payload/reset scenarios plus
// randomized lane streams checked every cycle against a bit-history reference model.
module tb_phy_rx;
  import phy_pkg::*;

  localparam logic [7:0] COM  = COM_SYM_DEF;
  localparam int         SYNC = SYNC_COUNT_DEF;

  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic       rx_in_0 = 1'b0;
  logic       rx_in_1 = 1'b0;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1, active_0, active_1;
`ifdef PHY_RX_STATUS_EN
  logic [7:0] com_count_0, com_count_1;
`endif

  always #5 clk_8f = ~clk_8f;

  phy_rx dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .enable     (enable),
    .rx_in_0    (rx_in_0),
    .rx_in_1    (rx_in_1),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .valid_out_0(valid_out_0),
    .valid_out_1(valid_out_1),
    .active_0   (active_0),
    .active_1   (active_1)
`ifdef PHY_RX_STATUS_EN
    ,
    .com_count_0(com_count_0),
    .com_count_1(com_count_1)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rise0 = -1;
  bit q0[$];
  bit q1[$];

  // Reference model: last 8 received bits, whether a byte grid is locked,
  // bits since the last boundary, commas counted toward sync, and outputs.
  logic [7:0] m_win [2];
  bit         m_lock[2];
  int         m_nb  [2];
  int         m_ncom[2];
  bit         m_act [2];
  bit         m_vld [2];
  logic [7:0] m_dat [2];
  int         m_cc  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic void m_reset();
    for (int l = 0; l < 2; l++) begin
      m_win[l] = 8'h00; m_lock[l] = 0; m_nb[l] = 0; m_ncom[l] = 0;
      m_act[l] = 0; m_vld[l] = 0; m_dat[l] = 8'h00; m_cc[l] = 0;
    end
  endfunction

  function automatic void m_step(int l, bit b);
    m_win[l] = {m_win[l][6:0], b};
    if (!enable) begin
      m_lock[l] = 0; m_ncom[l] = 0; m_act[l] = 0; m_vld[l] = 0; m_dat[l] = 8'h00; m_cc[l] = 0;
      return;
    end
    if (!m_lock[l]) begin
      if (m_win[l] == COM) begin
        m_lock[l] = 1; m_nb[l] = 0; m_ncom[l] = 1; m_act[l] = (SYNC <= 1);
      end
      return;
    end
    m_nb[l]++;
    if (m_nb[l] < 8) return;
    m_nb[l] = 0;
    if (m_act[l]) begin
      if (m_win[l] == COM) begin
        m_vld[l] = 0;
        if (m_cc[l] < 255) m_cc[l]++;
      end else begin
        m_vld[l] = 1; m_dat[l] = m_win[l];
      end
    end else if (m_win[l] == COM) begin
      m_ncom[l]++;
      if (m_ncom[l] == SYNC) m_act[l] = 1;
    end else begin
      m_lock[l] = 0; m_ncom[l] = 0;
    end
  endfunction

  task automatic push_bit(input int l, input bit b);
    if (l == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic push_byte(input int l, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_bit(l, v[i]);
  endtask

  function automatic logic [7:0] rnd_pl();
    logic [7:0] v;
    do v = 8'($urandom); while (v == COM);
    return v;
  endfunction

  task automatic tick();
    bit b0, b1;
    if (q0.size() > 0) b0 = q0.pop_front(); else b0 = 1'b0;
    if (q1.size() > 0) b1 = q1.pop_front(); else b1 = 1'b0;
    @(negedge clk_8f);
    rx_in_0 = b0;
    rx_in_1 = b1;
    @(posedge clk_8f);
    m_step(0, b0);
    m_step(1, b1);
    cyc++;
    #1;
    if (active_0 && rise0 < 0) rise0 = cyc;
    chk("lane0", 32'({active_0, valid_out_0, data_out_0}), 32'({m_act[0], m_vld[0], m_dat[0]}));
    chk("lane1", 32'({active_1, valid_out_1, data_out_1}), 32'({m_act[1], m_vld[1], m_dat[1]}));
`ifdef PHY_RX_STATUS_EN
    chk("cnt0", 32'(com_count_0), 32'(8'(m_cc[0])));
    chk("cnt1", 32'(com_count_1), 32'(8'(m_cc[1])));
`endif
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_all();
    while (q0.size() > 0 || q1.size() > 0) tick();
  endtask

  // Asserts reset between clock edges so the async clear is observed on its own.
  task automatic pulse_reset();
    #2 reset_L = 1'b0;
    #1;
    chk("rst_outs", 32'({active_1, active_0, valid_out_1, valid_out_0, data_out_1, data_out_0}), 32'd0);
    m_reset();
    cyc = 0;
    rise0 = -1;
    reset_L = 1'b1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk_8f);
    #1;
    pulse_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    do_reset();

    // Alignment from an arbitrary bit offset: 3 filler bits, then 5 commas.
    enable = 1'b1;
    repeat (3) push_bit(0, 1'b0);
    repeat (5) push_byte(0, COM);
    run_all();
    chk("active_rise_cycle", 32'(rise0), 32'(3 + 8 * SYNC));
    chk("active0_after_sync", 32'(active_0), 32'd1);
    chk("valid0_idle", 32'(valid_out_0), 32'd0);

    push_byte(0, 8'h5A);
    run_all();
    chk("data0_5A", 32'(data_out_0), 32'h5A);
    chk("valid0_5A", 32'(valid_out_0), 32'd1);
    push_byte(0, COM);
    run_all();
    chk("valid0_after_com", 32'(valid_out_0), 32'd0);
    chk("data0_hold", 32'(data_out_0), 32'h5A);

    enable = 1'b0;
    tick();
    chk("disable_outs", 32'({active_0, valid_out_0, data_out_0}), 32'd0);

    // Sync aborted by a non-comma byte, then a clean re-sync.
    do_reset();
    enable = 1'b1;
    push_byte(0, COM); push_byte(0, COM); push_byte(0, 8'h33);
    run_all();
    chk("abort_active0", 32'(active_0), 32'd0);
    repeat (SYNC) push_byte(0, COM);
    run_all();
    chk("resync_active0", 32'(active_0), 32'd1);

    // Lane 1 skewed 3 bits behind lane 0.
    do_reset();
    enable = 1'b1;
    repeat (3) push_bit(1, 1'b0);
    for (int l = 0; l < 2; l++) begin
      repeat (SYNC) push_byte(l, COM);
      push_byte(l, 8'h01);
      push_byte(l, 8'hFF);
    end
    run(40);
    chk("skew_l0_01", 32'({valid_out_0, data_out_0}), 32'h101);
    chk("skew_l1_idle", 32'({active_1, valid_out_1}), 32'b10);
    run(8);
    chk("skew_l0_FF", 32'({valid_out_0, data_out_0}), 32'h1FF);
    chk("skew_l1_01", 32'({valid_out_1, data_out_1}), 32'h101);
    run(3);
    chk("skew_l1_FF", 32'({valid_out_1, data_out_1}), 32'h1FF);

    // Reset in the middle of a payload byte.
    do_reset();
    enable = 1'b1;
    repeat (SYNC) push_byte(0, COM);
    push_byte(0, 8'h5A);
    push_bit(0, 1'b1); push_bit(0, 1'b1); push_bit(0, 1'b0); push_bit(0, 1'b0);
    run_all();
    chk("pre_reset_data0", 32'({active_0, valid_out_0, data_out_0}), 32'h35A);
    pulse_reset();
    repeat (SYNC - 1) push_byte(0, COM);
    run_all();
    chk("post_reset_not_active", 32'(active_0), 32'd0);
    push_byte(0, COM);
    run_all();
    chk("post_reset_active", 32'(active_0), 32'd1);

`ifdef PHY_RX_STATUS_EN
    do_reset();
    enable = 1'b1;
    repeat (SYNC + 300) push_byte(0, COM);
    run_all();
    chk("com_count_sat", 32'(com_count_0), 32'hFF);
    enable = 1'b0;
    tick();
    chk("com_count_clr", 32'({active_0, com_count_0}), 32'd0);
`endif

    // Randomized streams: random preamble, sync commas, mixed payload/idle bytes.
    for (int it = 0; it < 8; it++) begin
      int pre;
      do_reset();
      enable = 1'b1;
      for (int l = 0; l < 2; l++) begin
        pre = $urandom_range(0, 12);
        for (int k = 0; k < pre; k++) push_bit(l, 1'($urandom_range(0, 1)));
        repeat (SYNC + $urandom_range(0, 2)) push_byte(l, COM);
        for (int k = 0; k < 12; k++) begin
          if ($urandom_range(0, 3) == 0) push_byte(l, COM);
          else                           push_byte(l, rnd_pl());
        end
      end
      run(60);
      if (it % 3 == 2) begin
        enable = 1'b0;
        run(3);
        enable = 1'b1;
      end
      run_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
